// File: rtl/decoder_3_8_pkg.sv
// decoder_3_8_pkg
// Shared widths and types for the 3-to-8 decoder slice.
//   ONEHOT_W : width of the decoded one-hot vector
//   code_t   : 3-bit select code, {c1,c2,c3}
package decoder_3_8_pkg;

    localparam int ONEHOT_W = 8;

    typedef logic [2:0]          code_t;
    typedef logic [ONEHOT_W-1:0] onehot_t;

endpackage

// File: rtl/decoder_3_8_if.sv
// decoder_3_8_if
// Bundles the decoder enables, select code and the eight decoded lines.
//   master : drives e1_low, e2_low, e3, c1..c3; observes d1..d8
//   slave  : the decoder side (inputs/outputs mirrored)
interface decoder_3_8_if;

    logic e1_low;
    logic e2_low;
    logic e3;
    logic c1;
    logic c2;
    logic c3;
    logic d1, d2, d3, d4, d5, d6, d7, d8;

    modport master (
        output e1_low, e2_low, e3, c1, c2, c3,
        input  d1, d2, d3, d4, d5, d6, d7, d8
    );

    modport slave (
        input  e1_low, e2_low, e3, c1, c2, c3,
        output d1, d2, d3, d4, d5, d6, d7, d8
    );

endinterface

// File: rtl/decoder_3_8_core.sv
// decoder3_8_core
// Purely combinational 74x138-style decode with active-high one-hot output.
//   e1_low, e2_low : active-low enables
//   e3             : active-high enable
//   c[2:0]         : select code
//   y[7:0]         : y[c] = 1 when enabled, all zero otherwise
module decoder3_8_core
    import decoder_3_8_pkg::*;
(
    input  logic    e1_low,
    input  logic    e2_low,
    input  logic    e3,
    input  code_t   c,
    output onehot_t y
);

    logic en;

    assign en = ~e1_low & ~e2_low & e3;

    always_comb begin
        y = '0;
        if (en) begin
            y[c] = 1'b1;
        end
    end

endmodule

// File: rtl/decoder_3_8.sv
// decoder_3_8
// 3-to-8 line decoder with three-input enable and optional output register.
//   clk     : rising-edge clock (unused when OUT_REG = 0)
//   rst     : asynchronous active-high reset (unused when OUT_REG = 0)
//   bus     : enables, select code and decoded lines d1..d8
// OUT_REG = 1 gives flop-driven, glitch-free outputs with one cycle of latency;
// OUT_REG = 0 gives a zero-latency combinational decode.
module decoder_3_8
    import decoder_3_8_pkg::*;
#(
    parameter bit OUT_REG = 1'b1
) (
    input logic          clk,
    input logic          rst,
    decoder_3_8_if.slave bus
);

    onehot_t y_comb;
    onehot_t y_out;

    decoder3_8_core u_core (
        .e1_low (bus.e1_low),
        .e2_low (bus.e2_low),
        .e3     (bus.e3),
        .c      ({bus.c1, bus.c2, bus.c3}),
        .y      (y_comb)
    );

    generate
        if (OUT_REG) begin : g_reg
            onehot_t y_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    y_q <= '0;
                end else begin
                    y_q <= y_comb;
                end
            end

            assign y_out = y_q;
        end else begin : g_comb
            // Clock and reset have no load in the combinational build.
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst;
            assign y_out = y_comb;
        end
    endgenerate

    assign bus.d1 = y_out[0];
    assign bus.d2 = y_out[1];
    assign bus.d3 = y_out[2];
    assign bus.d4 = y_out[3];
    assign bus.d5 = y_out[4];
    assign bus.d6 = y_out[5];
    assign bus.d7 = y_out[6];
    assign bus.d8 = y_out[7];

endmodule

// File: tb/tb_decoder_3_8.sv
// tb_decoder_3_8
// Drives a registered and a combinational decoder from the same stimulus and
// compares both against a behavioural model every falling edge.
module tb_decoder_3_8;

    logic clk;
    logic rst;

    decoder_3_8_if bus_r ();
    decoder_3_8_if bus_c ();

    decoder_3_8 #(.OUT_REG(1'b1)) dut_reg (
        .clk (clk),
        .rst (rst),
        .bus (bus_r.slave)
    );

    decoder_3_8 #(.OUT_REG(1'b0)) dut_comb (
        .clk (clk),
        .rst (rst),
        .bus (bus_c.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_on  = 1'b0;

    logic [7:0] exp_reg;
    logic [7:0] dq_reg;
    logic [7:0] dq_comb;
    logic [2:0] en_bits;   // {e1_low, e2_low, e3}
    logic [2:0] code;

    logic [7:0] onehot_tbl [8] = '{8'h01, 8'h02, 8'h04, 8'h08,
                                   8'h10, 8'h20, 8'h40, 8'h80};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign dq_reg  = {bus_r.d8, bus_r.d7, bus_r.d6, bus_r.d5,
                      bus_r.d4, bus_r.d3, bus_r.d2, bus_r.d1};
    assign dq_comb = {bus_c.d8, bus_c.d7, bus_c.d6, bus_c.d5,
                      bus_c.d4, bus_c.d3, bus_c.d2, bus_c.d1};

    // Reference: output line k is high exactly when the part is enabled and
    // the code value equals k.
    function automatic logic [7:0] model(logic [2:0] en3, logic [2:0] cd);
        logic [7:0] r;
        bit enabled;
        enabled = (en3 == 3'b001);
        for (int k = 0; k < 8; k++) begin
            r[k] = enabled && (int'(cd) == k);
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h", name, got, exp);
        end
    endtask

    task automatic drive(input logic [2:0] e, input logic [2:0] c);
        en_bits = e;
        code    = c;
        {bus_r.e1_low, bus_r.e2_low, bus_r.e3} = e;
        {bus_c.e1_low, bus_c.e2_low, bus_c.e3} = e;
        {bus_r.c1, bus_r.c2, bus_r.c3} = c;
        {bus_c.c1, bus_c.c2, bus_c.c3} = c;
    endtask

    // Apply new inputs just after a rising edge so the next edge samples them.
    task automatic step(input logic [2:0] e, input logic [2:0] c);
        @(posedge clk);
        #1;
        drive(e, c);
    endtask

    // Model of the registered build: captures the decode of the inputs on
    // every rising edge, cleared while reset is high.
    always @(posedge clk or posedge rst) begin
        if (rst) exp_reg = 8'h00;
        else     exp_reg = model(en_bits, code);
    end

    always @(negedge clk) begin
        if (chk_on) begin
            check("reg_vs_model", dq_reg, exp_reg);
            check("comb_vs_model", dq_comb, model(en_bits, code));
            n_tests++;
            if ($countones(dq_reg) > 1) begin
                n_fail++;
                $display("FAIL reg_onehot: got %02h expected at most one bit set", dq_reg);
            end
        end
    end

    initial begin
        rst = 1'b0;
        drive(3'b001, 3'b101);
        #1 rst = 1'b1;
        #1;
        check("reset_async_entry", dq_reg, 8'h00);
        repeat (2) @(posedge clk);
        #1;
        check("reset_held", dq_reg, 8'h00);
        chk_on = 1'b1;
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("reset_release_d6", dq_reg, 8'h20);

        // Full sweep, one code per clock.
        for (int i = 0; i < 8; i++) begin
            step(3'b001, 3'(i));
            #1;
            check("comb_sweep_zero_latency", dq_comb, onehot_tbl[i]);
            @(posedge clk);
            @(negedge clk);
            check("reg_sweep", dq_reg, onehot_tbl[i]);
        end

        // Disable via e3.
        step(3'b000, 3'b111);
        @(posedge clk); @(negedge clk);
        check("disable_e3", dq_reg, 8'h00);

        // Disable via e1_low then e2_low, then re-enable.
        step(3'b101, 3'b011);
        @(posedge clk); @(negedge clk);
        check("disable_e1", dq_reg, 8'h00);
        step(3'b011, 3'b011);
        @(posedge clk); @(negedge clk);
        check("disable_e2", dq_reg, 8'h00);
        step(3'b001, 3'b011);
        @(posedge clk); @(negedge clk);
        check("reenable_d4", dq_reg, 8'h08);

        // Latency: code changes mid-cycle, registered output waits for the edge.
        step(3'b001, 3'b000);
        @(posedge clk); @(negedge clk);
        check("latency_d1_before", dq_reg, 8'h01);
        #2 drive(3'b001, 3'b111);
        #1;
        check("latency_d1_held", dq_reg, 8'h01);
        check("latency_comb_d8", dq_comb, 8'h80);
        @(posedge clk);
        #1;
        check("latency_d8_after", dq_reg, 8'h80);

        // Randomized traffic, roughly half the cycles enabled.
        for (int i = 0; i < 300; i++) begin
            logic [2:0] e;
            e = ($urandom_range(0, 1) == 0) ? 3'b001 : 3'($urandom_range(0, 7));
            step(e, 3'($urandom_range(0, 7)));
        end

        // Asynchronous reset asserted mid-cycle while an output is high.
        step(3'b001, 3'b010);
        @(posedge clk); @(negedge clk);
        check("pre_async_d3", dq_reg, 8'h04);
        #1 rst = 1'b1;
        #1;
        check("async_reset_mid_cycle", dq_reg, 8'h00);
        step(3'b001, 3'b110);
        rst = 1'b0;
        @(posedge clk); @(negedge clk);
        check("second_release_d7", dq_reg, 8'h40);

        repeat (2) @(posedge clk);
        chk_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
